// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the round-robin ALU arbiter.
package alu_arb_pkg;

    localparam int ALU_W = 16;
    localparam int RES_W = 17;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu16_core.sv
// Combinational 16-bit ALU; bit 16 carries carry (ADD) or borrow (SUB).
module alu16_core
    import alu_arb_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       op,
    output logic [RES_W-1:0] y
);

    logic [RES_W-1:0] ax, bx;

    assign ax = {1'b0, a};
    assign bx = {1'b0, b};

    always_comb begin
        y = '0;
        case (alu_op_e'(op))
            ADD:     y = ax + bx;
            SUB:     y = ax - bx;
            AND:     y = ax & bx;
            OR:      y = ax | bx;
            XOR:     y = ax ^ bx;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// Optional resp_err output for illegal opcodes under `define ALU_ARB_ERR_EN.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_in1,
    input  logic [NUM_REQ*ALU_W-1:0] req_in2,
    input  logic [NUM_REQ*3-1:0]     req_op,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [RES_W-1:0]         resp_data,
`ifdef ALU_ARB_ERR_EN
    output logic                     resp_err,
`endif
    output logic                     busy
);

    // First set bit strictly after ptr, wrapping; lowest offset wins.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] g;
        int idx;
        g = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[idx]) g = idx[ID_W-1:0];
        end
        return g;
    endfunction

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, g_q, pick;
    logic [ALU_W-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [RES_W-1:0] alu_y;
    logic             any_req;

    assign any_req = |req_valid;
    assign pick    = rr_pick(req_valid, rr_ptr_q);
    assign busy    = (state_q != IDLE);

    alu16_core u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: if (any_req) begin
                req_ready[pick] = 1'b1;
                state_d         = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            g_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
`ifdef ALU_ARB_ERR_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (any_req) begin
                    a_q      <= req_in1[pick*ALU_W +: ALU_W];
                    b_q      <= req_in2[pick*ALU_W +: ALU_W];
                    op_q     <= req_op[pick*3 +: 3];
                    g_q      <= pick;
                    rr_ptr_q <= pick;
                end
                EXEC: begin
                    resp_data  <= alu_y;
                    resp_id    <= g_q;
                    resp_valid <= 1'b1;
`ifdef ALU_ARB_ERR_EN
                    resp_err   <= (op_q > 3'd4);
`endif
                end
                RESP: if (resp_ready) resp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter with a behavioural reference model.
module tb_alu_rr_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_in1, req_in2;
    logic [N*3-1:0]  req_op;
    logic            resp_valid, resp_ready;
    logic [1:0]      resp_id;
    logic [16:0]     resp_data;
    logic            busy;
`ifdef ALU_ARB_ERR_EN
    logic            resp_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mdl_last = N - 1;
    int in1 [N];
    int in2 [N];
    int opv [N];
    int last_accept;

    alu_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
`ifdef ALU_ARB_ERR_EN
        .resp_err   (resp_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model_alu(int a, int b, int op);
        case (op)
            0:       return a + b;
            1:       return (a >= b) ? (a - b) : (a - b + 131072);
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return 0;
        endcase
    endfunction

    function automatic int model_pick(logic [N-1:0] mask, int last);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_in1[i*16 +: 16] = in1[i][15:0];
            req_in2[i*16 +: 16] = in2[i][15:0];
            req_op[i*3 +: 3]    = opv[i][2:0];
        end
    endtask

    // Starts and ends just after a negedge with the DUT idle.
    task automatic txn(input logic [N-1:0] mask, input int stall, input string nm);
        int g, exp_d;
        logic [N-1:0] exp_r;
        drive_ops();
        req_valid  = mask;
        resp_ready = (stall == 0);
        #1;
        checks++;
        if (mask == 0) begin
            if (req_ready !== '0) begin
                errors++; $display("FAIL %s idle_ready got=%b want=0", nm, req_ready);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL %s idle_busy got=%b want=0", nm, busy);
            end
            return;
        end
        g     = model_pick(mask, mdl_last);
        exp_r = '0;
        exp_r[g] = 1'b1;
        if (req_ready !== exp_r) begin
            errors++; $display("FAIL %s grant got=%b want=%b", nm, req_ready, exp_r);
        end
        exp_d    = model_alu(in1[g], in2[g], opv[g]);
        mdl_last = g;
        last_accept = cyc;
        @(negedge clk);
        // scramble everything after the accept edge; result must not change
        for (int i = 0; i < N; i++) begin
            in1[i] = $urandom_range(0, 65535);
            in2[i] = $urandom_range(0, 65535);
            opv[i] = $urandom_range(0, 7);
        end
        drive_ops();
        req_valid = N'($urandom);
        #1;
        checks++;
        if (req_ready !== '0 || busy !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s exec ready=%b busy=%b rv=%b want 0/1/0",
                               nm, req_ready, busy, resp_valid);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 17'(exp_d) || resp_id !== 2'(g)) begin
            errors++; $display("FAIL %s resp rv=%b data=%h id=%0d want 1/%h/%0d",
                               nm, resp_valid, resp_data, resp_id, 17'(exp_d), g);
        end
`ifdef ALU_ARB_ERR_EN
        checks++;
        if (resp_err !== (opv_saved_err(exp_d, g))) begin
            errors++; $display("FAIL %s resp_err got=%b", nm, resp_err);
        end
`endif
        for (int s = 0; s < stall; s++) begin
            req_valid = N'($urandom);
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 17'(exp_d) ||
                resp_id !== 2'(g) || req_ready !== '0) begin
                errors++; $display("FAIL %s stall%0d rv=%b data=%h id=%0d ready=%b want 1/%h/%0d/0",
                                   nm, s, resp_valid, resp_data, resp_id, req_ready, 17'(exp_d), g);
            end
        end
        resp_ready = 1'b1;
        req_valid  = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s release busy=%b rv=%b want 0/0", nm, busy, resp_valid);
        end
    endtask

`ifdef ALU_ARB_ERR_EN
    int err_op_at_accept;
    function automatic logic opv_saved_err(int d, int g);
        return (err_op_at_accept > 4);
    endfunction
`endif

    task automatic set_req(int i, int a, int b, int op);
        in1[i] = a; in2[i] = b; opv[i] = op;
`ifdef ALU_ARB_ERR_EN
        err_op_at_accept = op;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 0);
        drive_ops();
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 0 || resp_id !== 0 || resp_data !== 0 || busy !== 0 || req_ready !== 0) begin
            errors++; $display("FAIL reset rv=%b id=%0d data=%h busy=%b ready=%b want zeros",
                               resp_valid, resp_id, resp_data, busy, req_ready);
        end
`ifdef ALU_ARB_ERR_EN
        checks++;
        if (resp_err !== 1'b0) begin
            errors++; $display("FAIL reset_err got=%b want=0", resp_err);
        end
`endif
        rst_n = 1'b1;
        mdl_last = N - 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        set_req(0, 16'h0005, 16'h0003, 0); txn(4'b0001, 0, "add0");
        set_req(1, 16'h0003, 16'h0005, 1); txn(4'b0010, 0, "sub_borrow");
        set_req(2, 16'hFFFF, 16'h0001, 0); txn(4'b0100, 0, "add_carry");
    endtask

    task automatic test_stall();
        set_req(3, 16'h1234, 16'h00FF, 2); txn(4'b1000, 5, "stall");
    endtask

    task automatic test_rotate();
        int prev;
        int order [5] = '{0, 1, 2, 3, 0};
        prev = -1;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 4));
            err_sync(order[n]);
            txn(4'b1111, 0, "rotate");
            checks++;
            if (mdl_last != order[n] || (prev >= 0 && last_accept - prev != 3)) begin
                errors++; $display("FAIL rotate%0d grant=%0d want=%0d gap=%0d want=3",
                                   n, mdl_last, order[n], last_accept - prev);
            end
            prev = last_accept;
        end
    endtask

    task automatic err_sync(int g);
`ifdef ALU_ARB_ERR_EN
        err_op_at_accept = opv[g];
`else
        if (g < 0) $display("bad index");
`endif
    endtask

    task automatic test_err();
        set_req(1, 16'hABCD, 16'h1111, 6); txn(4'b0010, 0, "illegal_op");
        set_req(2, 16'hF0F0, 16'hFF00, 4); txn(4'b0100, 0, "xor");
        checks++;
        if (resp_data !== 17'h00FF0) begin
            errors++; $display("FAIL xor_value got=%h want=00ff0", resp_data);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        int g;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N; i++)
                set_req(i, $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 7));
            m = N'($urandom);
            g = model_pick(m, mdl_last);
            if (g >= 0) err_sync(g);
            txn(m, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_reset_mid();
        set_req(2, 16'h0101, 16'h0202, 0);
        drive_ops();
        req_valid = 4'b0100; resp_ready = 1'b0;
        @(negedge clk);                 // now EXEC
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 0 || busy !== 0) begin
            errors++; $display("FAIL rst_exec rv=%b busy=%b want 0/0", resp_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = N - 1;
        req_valid = 4'b0100;
        @(negedge clk);                 // EXEC
        @(negedge clk);                 // RESP, held by resp_ready=0
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 0 || busy !== 0) begin
            errors++; $display("FAIL rst_resp rv=%b busy=%b want 0/0", resp_valid, busy);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_last = N - 1;
        for (int i = 0; i < N; i++) set_req(i, i + 1, 2, 0);
        err_sync(0);
        txn(4'b1111, 0, "after_reset");
        checks++;
        if (mdl_last != 0) begin
            errors++; $display("FAIL after_reset_grant got=%0d want=0", mdl_last);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_rotate();
        test_err();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
